// File: rtl/bcp_scan_unit_if.sv
// Implication stream channel of bcp_scan_unit.
// master drives implications, slave consumes them.
interface bcp_scan_unit_if #(
  parameter int VAR_W = 3,
  parameter int CLS_W = 3
);
  logic             imp_valid;
  logic             imp_ready;
  logic [VAR_W-1:0] imp_var;
  logic             imp_value;
  logic [CLS_W-1:0] imp_clause;

  modport master (
    output imp_valid,
    output imp_var,
    output imp_value,
    output imp_clause,
    input  imp_ready
  );

  modport slave (
    input  imp_valid,
    input  imp_var,
    input  imp_value,
    input  imp_clause,
    output imp_ready
  );
endinterface

// File: rtl/bcp_scan_unit.sv
// BCP clause bank: per pass reports lowest conflict or streams unit implications.
// Optional BCP_DEDUP_EN: skip repeated implications, stop on contradictory ones.
module bcp_scan_unit #(
  parameter  int VAR_NUM    = 8,
  parameter  int CLAUSE_NUM = 8,
  localparam int VAR_W      = $clog2(VAR_NUM),
  localparam int CLS_W      = $clog2(CLAUSE_NUM)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [CLS_W-1:0]   load_idx,
  input  logic               load_en,
  input  logic [VAR_NUM-1:0] load_type,
  input  logic [VAR_NUM-1:0] load_mask,
  input  logic               start,
  input  logic [VAR_NUM-1:0] free,
  input  logic [VAR_NUM-1:0] assignment,
  output logic               busy,
  output logic               done,
  output logic               conflict,
  output logic [CLS_W-1:0]   conflict_clause,
  output logic [CLS_W:0]     imp_count,
  bcp_scan_unit_if.master    imp
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    SCAN,
    DONE
  } state_t;

  state_t state;

  logic [CLAUSE_NUM-1:0] cls_en;
  logic [VAR_NUM-1:0]    cls_type [CLAUSE_NUM];
  logic [VAR_NUM-1:0]    cls_mask [CLAUSE_NUM];
  logic [VAR_NUM-1:0]    free_q;
  logic [VAR_NUM-1:0]    asg_q;
  logic [CLAUSE_NUM-1:0] pending;

  logic [VAR_NUM-1:0]    fv [CLAUSE_NUM];
  logic [CLAUSE_NUM-1:0] sat;
  logic [CLAUSE_NUM-1:0] unit_c;
  logic [CLAUSE_NUM-1:0] confl_c;
  logic [VAR_W-1:0]      uvar [CLAUSE_NUM];
  logic [CLAUSE_NUM-1:0] uval;

  logic [CLAUSE_NUM-1:0] nxt_pend;
  logic [CLS_W-1:0]      nxt_head;
  logic [CLS_W-1:0]      first_unit;
  logic                  fire;
  logic                  dup;
  logic                  contra;

`ifdef BCP_DEDUP_EN
  logic [VAR_NUM-1:0] impl_mask;
  logic [VAR_NUM-1:0] impl_val;
  logic [VAR_NUM-1:0] acc_mask;
  logic [VAR_NUM-1:0] acc_val;
`endif

  function automatic logic [CLS_W-1:0] low_idx(
    input logic [CLAUSE_NUM-1:0] vec
  );
    logic [CLS_W-1:0] r;
    r = '0;
    for (int i = CLAUSE_NUM - 1; i >= 0; i--)
      if (vec[i]) r = CLS_W'(i);
    return r;
  endfunction

  // Clause evaluation against the snapshot taken at start
  always_comb begin
    unit_c  = '0;
    confl_c = '0;
    sat     = '0;
    uval    = '0;
    for (int c = 0; c < CLAUSE_NUM; c++) begin
      fv[c]  = cls_mask[c] & free_q;
      sat[c] = |(cls_mask[c] & ~free_q
                 & ~(asg_q ^ cls_type[c]));
      unit_c[c] = cls_en[c] & ~sat[c]
                  & (fv[c] != '0)
                  & ((fv[c] & (fv[c] - 1'b1)) == '0);
      confl_c[c] = cls_en[c] & ~sat[c]
                   & (fv[c] == '0);
      uvar[c] = '0;
      for (int v = VAR_NUM - 1; v >= 0; v--)
        if (fv[c][v]) uvar[c] = VAR_W'(v);
      uval[c] = cls_type[c][uvar[c]];
    end
  end

  // Next head after the current one retires (accepted or skipped)
  always_comb begin
    fire       = ~imp.imp_valid | imp.imp_ready;
    nxt_pend   = pending & (pending - 1'b1);
    nxt_head   = low_idx(nxt_pend);
    first_unit = low_idx(unit_c);
    dup        = 1'b0;
    contra     = 1'b0;
`ifdef BCP_DEDUP_EN
    acc_mask = impl_mask;
    acc_val  = impl_val;
    if (imp.imp_valid) begin
      acc_mask[imp.imp_var] = 1'b1;
      acc_val[imp.imp_var]  = imp.imp_value;
    end
    if (acc_mask[uvar[nxt_head]]) begin
      dup    = acc_val[uvar[nxt_head]] == uval[nxt_head];
      contra = ~dup;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      cls_en          <= '0;
      for (int c = 0; c < CLAUSE_NUM; c++) begin
        cls_type[c] <= '0;
        cls_mask[c] <= '0;
      end
      free_q          <= '0;
      asg_q           <= '0;
      pending         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      conflict        <= 1'b0;
      conflict_clause <= '0;
      imp_count       <= '0;
      imp.imp_valid   <= 1'b0;
      imp.imp_var     <= '0;
      imp.imp_value   <= 1'b0;
      imp.imp_clause  <= '0;
`ifdef BCP_DEDUP_EN
      impl_mask       <= '0;
      impl_val        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            cls_en[load_idx]   <= load_en;
            cls_type[load_idx] <= load_type;
            cls_mask[load_idx] <= load_mask;
          end
          if (start) begin
            free_q          <= free;
            asg_q           <= assignment;
            imp_count       <= '0;
            conflict        <= 1'b0;
            conflict_clause <= '0;
            busy            <= 1'b1;
            state           <= EVAL;
`ifdef BCP_DEDUP_EN
            impl_mask       <= '0;
            impl_val        <= '0;
`endif
          end
        end
        EVAL: begin
          pending <= unit_c;
          if (|confl_c) begin
            conflict        <= 1'b1;
            conflict_clause <= low_idx(confl_c);
            done            <= 1'b1;
            state           <= DONE;
          end else if (unit_c == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            imp.imp_valid  <= 1'b1;
            imp.imp_var    <= uvar[first_unit];
            imp.imp_value  <= uval[first_unit];
            imp.imp_clause <= first_unit;
            state          <= SCAN;
          end
        end
        SCAN: begin
          if (fire) begin
            pending <= nxt_pend;
            if (imp.imp_valid) begin
              imp_count <= imp_count + 1'b1;
`ifdef BCP_DEDUP_EN
              impl_mask <= acc_mask;
              impl_val  <= acc_val;
`endif
            end
            imp.imp_var    <= uvar[nxt_head];
            imp.imp_value  <= uval[nxt_head];
            imp.imp_clause <= nxt_head;
            if (nxt_pend == '0) begin
              imp.imp_valid <= 1'b0;
              done          <= 1'b1;
              state         <= DONE;
            end else if (contra) begin
              imp.imp_valid   <= 1'b0;
              conflict        <= 1'b1;
              conflict_clause <= nxt_head;
              done            <= 1'b1;
              state           <= DONE;
            end else begin
              imp.imp_valid <= ~dup;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
